// File: rtl/alu_seq_mb.sv
// Multi-byte sequencer that issues a wide operation to an 8-bit combinational ALU, LSB first.
// Optional signed-overflow output `ovf` is built when ALU_SEQ_OVF_EN is defined.
module alu_seq_mb #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [2:0]            alu_cs,
  output logic                  alu_cin,
  input  logic [7:0]            alu_s,
  input  logic                  alu_zero,
  input  logic                  alu_cout,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry,
  output logic                  zero
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_LTU = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [W-1:0]  a_q, b_q;
  logic [2:0]    op_q;
  logic [IW-1:0] idx;
  logic          chain, chain_next;
  logic          last_byte;
  logic          accept;
  logic [W-1:0]  result_next;

  // Zero is taken over the whole wide result, so the per-byte flag is not needed.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  assign accept    = (state == IDLE) && start;
  assign last_byte = (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_byte) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_a   = 8'd0;
    alu_b   = 8'd0;
    alu_cs  = 3'b000;
    alu_cin = 1'b0;
    busy    = (state != IDLE);
    done    = (state == DONE);
    if (state == RUN) begin
      alu_a = a_q[8*idx +: 8];
      alu_b = b_q[8*idx +: 8];
      // Only the carry-producing ALU codes are used so carry_out is fresh at every byte.
      case (op_q)
        OP_OR:          alu_cs = 3'b001;
        OP_ADD:         begin alu_cs = 3'b110; alu_cin = chain; end
        OP_SUB, OP_LTU: begin alu_cs = 3'b101; alu_cin = chain; end
        default:        alu_cs = 3'b000;
      endcase
    end
  end

  // The subtract path adds ~cin, so the chain holds borrow rather than carry.
  always_comb begin
    case (op_q)
      OP_ADD:         chain_next = alu_cout;
      OP_SUB, OP_LTU: chain_next = ~alu_cout;
      default:        chain_next = 1'b0;
    endcase
    result_next = result;
    result_next[8*idx +: 8] = alu_s;
    if ((op_q == OP_LTU) && last_byte)
      result_next = {{(W-1){1'b0}}, chain_next};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_AND;
      idx    <= '0;
      chain  <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      op_q  <= (op > OP_LTU) ? OP_AND : op;
      idx   <= '0;
      chain <= 1'b0;
    end else if (state == RUN) begin
      result <= result_next;
      chain  <= chain_next;
      if (last_byte) begin
        carry <= chain_next;
        zero  <= (result_next == '0);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic ovf_next;

  always_comb begin
    case (op_q)
      OP_ADD:  ovf_next = (a_q[W-1] == b_q[W-1]) && (result_next[W-1] != a_q[W-1]);
      OP_SUB:  ovf_next = (a_q[W-1] != b_q[W-1]) && (result_next[W-1] != a_q[W-1]);
      default: ovf_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            ovf <= 1'b0;
    else if ((state == RUN) && last_byte) ovf <= ovf_next;
  end
`endif

endmodule

// File: tb/tb_alu_seq_mb.sv
// Self-checking bench for alu_seq_mb with a behavioural 8-bit ALU attached.
// Overflow checks are included when ALU_SEQ_OVF_EN is defined.
module tb_alu_seq_mb;

  localparam int NBYTES = 2;
  localparam int W = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic [7:0]   alu_a, alu_b, alu_s;
  logic [2:0]   alu_cs;
  logic         alu_cin, alu_zero, alu_cout;
  logic         busy, done, carry, zero;
  logic [W-1:0] result;
`ifdef ALU_SEQ_OVF_EN
  logic         ovf;
`endif
  logic [8:0]   alu_sum;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq_mb #(.NBYTES(NBYTES)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cs   (alu_cs),
    .alu_cin  (alu_cin),
    .alu_s    (alu_s),
    .alu_zero (alu_zero),
    .alu_cout (alu_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .zero     (zero)
`ifdef ALU_SEQ_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  // Combinational 8-bit ALU: 101 computes a + ~b + ~cin, so carry_out high means no borrow.
  always_comb begin
    alu_sum  = 9'd0;
    alu_s    = alu_a & alu_b;
    alu_cout = 1'b0;
    case (alu_cs)
      3'b001: alu_s = alu_a | alu_b;
      3'b110: begin
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_s    = alu_sum[7:0];
        alu_cout = alu_sum[8];
      end
      3'b101: begin
        alu_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, ~alu_cin};
        alu_s    = alu_sum[7:0];
        alu_cout = alu_sum[8];
      end
      default: ;
    endcase
    alu_zero = (alu_s == 8'd0);
  end

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] s;
    e   = '0;
    s   = '0;
    case (o)
      3'd1: e.res = x | y;
      3'd2: begin
        s     = {1'b0, x} + {1'b0, y};
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      3'd3: begin
        e.res = x - y;
        e.c   = (x < y);
        e.v   = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      3'd4: begin
        e.c   = (x < y);
        e.res = {{(W-1){1'b0}}, e.c};
      end
      default: e.res = x & y;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one operation, optionally re-pulses start while busy, and checks timing and results.
  task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input bit pulse_extra);
    exp_t e;
    int   cycles;
    int   busy_cnt;
    int   extra_done;
    bit   seen;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    start    = 1'b0;
    a        = ~x;
    b        = ~y;
    cycles   = 1;
    busy_cnt = 0;
    seen     = 1'b0;
    while (cycles <= 20) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = pulse_extra && (cycles == 1);
      if (start) begin
        op = 3'd2;
        a  = 16'h1111;
        b  = 16'h2222;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    e = sb.pop_front();
    checkOutput({tag, " done_seen"}, seen, 1);
    checkOutput({tag, " latency"}, cycles, NBYTES + 1);
    checkOutput({tag, " busy_cycles"}, busy_cnt, NBYTES + 1);
    checkOutput({tag, " result"}, result, e.res);
    checkOutput({tag, " carry"}, carry, e.c);
    checkOutput({tag, " zero"}, zero, e.z);
`ifdef ALU_SEQ_OVF_EN
    checkOutput({tag, " ovf"}, ovf, e.v);
`endif
    @(negedge clk);
    checkOutput({tag, " done_one_cycle"}, done, 0);
    checkOutput({tag, " busy_cleared"}, busy, 0);
    if (pulse_extra) begin
      extra_done = 0;
      repeat (NBYTES + 3) begin
        @(negedge clk);
        if (done) extra_done++;
      end
      checkOutput({tag, " no_second_done"}, extra_done, 0);
      checkOutput({tag, " result_held"}, result, e.res);
    end
  endtask

  initial begin
    int done_cnt;
    $display("[TB] starting alu_seq_mb bench, NBYTES=%0d", NBYTES);
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset result", result, 0);
    checkOutput("reset carry", carry, 0);
    checkOutput("reset zero", zero, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset alu_a", alu_a, 0);
    checkOutput("reset alu_cs", alu_cs, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("add_00ff_0001", 3'd2, 16'h00FF, 16'h0001, 1'b0);
    applyStimulus("add_ffff_0001", 3'd2, 16'hFFFF, 16'h0001, 1'b0);
    applyStimulus("sub_0100_0001", 3'd3, 16'h0100, 16'h0001, 1'b0);
    applyStimulus("sub_0000_0001", 3'd3, 16'h0000, 16'h0001, 1'b0);
    applyStimulus("ltu_lt",        3'd4, 16'h1234, 16'h1235, 1'b0);
    applyStimulus("ltu_ge",        3'd4, 16'h1235, 16'h1234, 1'b0);
    applyStimulus("and",           3'd0, 16'hF0F0, 16'h3C3C, 1'b0);
    applyStimulus("or_busy_start", 3'd1, 16'hF0F0, 16'h3C3C, 1'b1);
    applyStimulus("reserved_op",   3'd7, 16'hF0F0, 16'h3C3C, 1'b0);

    // Abandon an ADD after its low byte has been captured.
    start = 1'b1;
    op    = 3'd2;
    a     = 16'h00FF;
    b     = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("midrun busy", busy, 1);
    checkOutput("midrun partial result", result, 16'h3000);
    rst = 1'b1;
    #1;
    checkOutput("midrun rst result", result, 0);
    checkOutput("midrun rst busy", busy, 0);
    checkOutput("midrun rst done", done, 0);
    checkOutput("midrun rst carry", carry, 0);
    checkOutput("midrun rst alu_a", alu_a, 0);
    checkOutput("midrun rst alu_b", alu_b, 0);
    checkOutput("midrun rst alu_cs", alu_cs, 0);
    checkOutput("midrun rst alu_cin", alu_cin, 0);
    @(negedge clk);
    rst      = 1'b0;
    done_cnt = 0;
    repeat (NBYTES + 3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("midrun no done", done_cnt, 0);

    applyStimulus("add_after_rst", 3'd2, 16'h0001, 16'h0001, 1'b0);

`ifdef ALU_SEQ_OVF_EN
    applyStimulus("ovf_add_pos", 3'd2, 16'h7FFF, 16'h0001, 1'b0);
    applyStimulus("ovf_sub_neg", 3'd3, 16'h8000, 16'h0001, 1'b0);
    applyStimulus("ovf_add_none", 3'd2, 16'h0001, 16'h0001, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_seq_mb.md
Name: alu_seq_mb

Overview:
- Multi-byte arithmetic sequencer: the initiator side of the 8-bit ALU's operand/CS/carry interface.
- Accepts one wide operation and issues it to the ALU one byte per cycle, least-significant byte first, chaining carry/borrow between bytes.
- Collects the ALU's S/zero/carry_out responses into a wide result and flags.
- Sits between the control unit and the ALU. The ALU is combinational, and its response is sampled in the same cycle it is driven.

Parameters:
- NBYTES, 2, operand width in bytes (W = 8*NBYTES); legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 LTU (unsigned a<b); 101-111 reserved, treated as AND.
- a  in  W  operand A; latched on accepted start.
- b  in  W  operand B; latched on accepted start.
- alu_a  out  8  current byte of A to ALU data_a.
- alu_b  out  8  current byte of B to ALU data_b.
- alu_cs  out  3  ALU function code.
- alu_cin  out  1  ALU carry_in.
- alu_s  in  8  ALU S.
- alu_zero  in  1  ALU zero; unused, zero is computed over the full result.
- alu_cout  in  1  ALU carry_out.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- result  out  W  final result; held until next accepted start.
- carry  out  1  ADD: carry out; SUB/LTU: borrow out; AND/OR: 0.
- zero  out  1  result == 0.

Behaviour:
- Reset, asynchronous:
  - state IDLE, byte index 0.
  - result, carry, zero, done, busy all 0.
  - alu_a, alu_b, alu_cs, alu_cin all 0.
  - Reset mid-RUN abandons the operation; no done is produced.
- States and transitions:
  - IDLE, start=1: latch a, b, op; clear index and chain bit; go to RUN.
  - RUN, index i: drive byte i. At the clock edge, capture alu_s into result[8i+7:8i] and update the chain bit.
  - RUN: if i = NBYTES-1, go to DONE; otherwise i+1.
  - DONE: done=1 for exactly one cycle; carry and zero become valid; then IDLE.
- Latency: start accepted at edge E0 gives done high in the cycle following edge E(NBYTES), i.e. NBYTES+1 cycles from acceptance to the end of the done pulse. Back-to-back starts are accepted in IDLE only, so throughput is one operation per NBYTES+2 cycles.
- start while busy is ignored, not queued. a and b may change after acceptance without effect.
- ALU drive per op, with c = chain bit:
  - AND: cs=000, cin=0.
  - OR: cs=001, cin=0.
  - ADD: cs=110, cin=c (0 at byte 0); c <= alu_cout.
  - SUB/LTU: cs=101, cin=borrow (0 at byte 0). The ALU adds ~cin, so the chain stores borrow = ~alu_cout.
  - Codes 010/011 (no-carry forms) are never used, because carry_out must be fresh at every byte.
- Final flags:
  - ADD: carry = c.
  - SUB: carry = borrow.
  - LTU: result = {W-1 zeros, borrow}; carry = borrow.
  - AND/OR: carry = 0.
  - All ops: zero = (result == 0), computed from the full W-bit result, not the per-byte alu_zero.
- Outputs are registered. result, carry and zero hold from DONE until the next accepted start. Intermediate result bytes may be visible while in RUN.
- NBYTES=1: single RUN cycle, with cin=0 for ADD and borrow-in 0 for SUB.

Optional Feature:
- Macro ALU_SEQ_OVF_EN.
- Defined: adds output port ovf (1 bit), reset 0, valid with done, held like result. It flags signed two's-complement overflow over W bits:
  - ADD: a[W-1]==b[W-1] and result[W-1]!=a[W-1].
  - SUB: a[W-1]!=b[W-1] and result[W-1]!=a[W-1].
  - Other ops: 0.
- Undefined: no ovf port and no overflow logic; all other behaviour is identical.

Test Plan:
- NBYTES=2 with the real ALU attached. ADD 0x00FF+0x0001 -> result 0x0100, carry 0, zero 0. done is high exactly one cycle, 2 edges after the start edge; busy is high for 3 cycles.
- ADD 0xFFFF+0x0001 -> result 0x0000, carry 1, zero 1. SUB 0x0100-0x0001 -> 0x00FF, carry 0. SUB 0x0000-0x0001 -> 0xFFFF, carry 1.
- LTU a=0x1234, b=0x1235 -> result 0x0001, carry 1. Then a=0x1235, b=0x1234 -> result 0x0000, zero 1, carry 0.
- AND 0xF0F0&0x3C3C -> 0x3030; OR -> 0xFCFC; both carry 0. A second start pulsed during busy is ignored: exactly one done, and the result reflects the first op.
- Assert rst during RUN (after byte 0): all outputs 0 immediately, no done. A fresh ADD 0x0001+0x0001 then yields 0x0002.
- With ALU_SEQ_OVF_EN: ADD 0x7FFF+0x0001 -> ovf 1; SUB 0x8000-0x0001 -> ovf 1; ADD 0x0001+0x0001 -> ovf 0.
